// File: rtl/sound_sequencer.sv
// rtl/sound_sequencer.sv - steps a ROM of sound-effect records and drives the sound_generator controls
module sound_sequencer #(
  parameter int TICK_DIV = 41667
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [2:0]  effect_id,
  output logic        busy,
  output logic        done,
  output logic [9:0]  lfo_freq,
  output logic [11:0] noise_freq,
  output logic [11:0] vco_freq,
  output logic        vco_select,
  output logic        noise_select,
  output logic [2:0]  lfo_shift,
  output logic [2:0]  mixer
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  state_t        state, state_next;
  logic [2:0]    effect, effect_next;
  logic [2:0]    step, step_next;
  logic [TW-1:0] tick_cnt, tick_next;
  logic [7:0]    dur_cnt, dur_next;
  logic          done_next;
  logic [9:0]    lfo_next;
  logic [11:0]   noise_next, vco_next;
  logic          vsel_next, nsel_next;
  logic [2:0]    shift_next, mixer_next;

  logic [7:0]    rom_dur, rom_sweep;
  logic [11:0]   rom_vco, rom_noise;
  logic [9:0]    rom_lfo;
  logic          rom_vsel, rom_nsel;
  logic [2:0]    rom_shift, rom_mix;

  logic signed [13:0] vco_sum;
  logic [11:0]        vco_sat;

  // Effect records; any entry not listed reads as dur==0, the end marker.
  always_comb begin
    rom_dur   = 8'd0;
    rom_vco   = 12'd0;
    rom_sweep = 8'd0;
    rom_noise = 12'd0;
    rom_lfo   = 10'd0;
    rom_vsel  = 1'b0;
    rom_nsel  = 1'b0;
    rom_shift = 3'd0;
    rom_mix   = 3'd0;
    case ({effect, step})
      6'o00: begin
        rom_dur   = 8'd4;
        rom_vco   = 12'd250;
        rom_noise = 12'd90;
        rom_lfo   = 10'd1000;
        rom_mix   = 3'b001;
      end
      6'o10: begin
        rom_dur   = 8'd3;
        rom_vco   = 12'd4090;
        rom_sweep = 8'sd5;
        rom_mix   = 3'b001;
      end
      6'o11: begin
        rom_dur   = 8'd2;
        rom_vco   = 12'd3;
        rom_sweep = -8'sd2;
        rom_mix   = 3'b001;
      end
      default: ;
    endcase
  end

  // Effect and step are frozen during PLAY, so the ROM sweep is the current step's.
  assign vco_sum = $signed({2'b00, vco_freq}) + $signed({{6{rom_sweep[7]}}, rom_sweep});
  assign vco_sat = (vco_sum < 0) ? 12'd0 :
                   (vco_sum > 14'sd4095) ? 12'hfff : vco_sum[11:0];

  assign busy = (state != IDLE);

  always_comb begin
    state_next  = state;
    effect_next = effect;
    step_next   = step;
    tick_next   = tick_cnt;
    dur_next    = dur_cnt;
    done_next   = 1'b0;
    lfo_next    = lfo_freq;
    noise_next  = noise_freq;
    vco_next    = vco_freq;
    vsel_next   = vco_select;
    nsel_next   = noise_select;
    shift_next  = lfo_shift;
    mixer_next  = mixer;
    if (trigger) begin
      effect_next = effect_id;
      step_next   = 3'd0;
      state_next  = LOAD;
    end else begin
      case (state)
        LOAD: begin
          if (rom_dur == 8'd0) begin
            state_next = IDLE;
            mixer_next = 3'd0;
            done_next  = 1'b1;
          end else begin
            lfo_next   = rom_lfo;
            noise_next = rom_noise;
            vco_next   = rom_vco;
            vsel_next  = rom_vsel;
            nsel_next  = rom_nsel;
            shift_next = rom_shift;
            mixer_next = rom_mix;
            dur_next   = rom_dur;
            tick_next  = '0;
            state_next = PLAY;
          end
        end
        PLAY: begin
          if (tick_cnt == TICK_LAST) begin
            tick_next = '0;
            vco_next  = vco_sat;
            dur_next  = dur_cnt - 8'd1;
            if (dur_cnt == 8'd1) begin
              if (step == 3'd7) begin
                state_next = IDLE;
                mixer_next = 3'd0;
                done_next  = 1'b1;
              end else begin
                step_next  = step + 3'd1;
                state_next = LOAD;
              end
            end
          end else begin
            tick_next = tick_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      effect       <= 3'd0;
      step         <= 3'd0;
      tick_cnt     <= '0;
      dur_cnt      <= 8'd0;
      done         <= 1'b0;
      lfo_freq     <= 10'd0;
      noise_freq   <= 12'd0;
      vco_freq     <= 12'd0;
      vco_select   <= 1'b0;
      noise_select <= 1'b0;
      lfo_shift    <= 3'd0;
      mixer        <= 3'd0;
    end else begin
      state        <= state_next;
      effect       <= effect_next;
      step         <= step_next;
      tick_cnt     <= tick_next;
      dur_cnt      <= dur_next;
      done         <= done_next;
      lfo_freq     <= lfo_next;
      noise_freq   <= noise_next;
      vco_freq     <= vco_next;
      vco_select   <= vsel_next;
      noise_select <= nsel_next;
      lfo_shift    <= shift_next;
      mixer        <= mixer_next;
    end
  end

endmodule
